multicycle_seq: RTL and testbench

- Multi-cycle sequencer for the ARM core. It steps the datapath through FETCH, DECODE, EXEC, MEM and WB.
- It drives the single shared memory port with a req/ack handshake.
- It gates the decoder's write strobes (register, flag, memory) so each fires in exactly one cycle per instruction.
- It sits between the combinational instruction decoder, the register file/CPSR, and the memory interface.

---
 rtl/multicycle_seq.sv | 198 +++++++++++++++++++
 tb/tb_multicycle_seq.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_seq.sv
//------------------------------------------------------------------------------
// Module      : multicycle_seq
// Description : Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the ARM core.
//               It drives the shared memory port and gates the decoder's write strobes.
//               Optional macro SEQ_MEM_TIMEOUT_EN adds the memory-wait timeout fault.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module multicycle_seq #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_ack,
    input  logic             cond_pass,
    input  logic             datapr,
    input  logic             ldstr,
    input  logic             l_bit,
    input  logic             regwrite_dec,
    input  logic             flagupdate_dec,
    input  logic             wb_base,
    output logic             mem_req,
    output logic             mem_ifetch,
    output logic             mem_we,
    output logic             ir_we,
    output logic             pc_we,
    output logic             reg_we,
    output logic             reg_we_base,
    output logic             flag_we,
    output logic             retire,
    output logic [CNT_W-1:0] instret,
    output logic [2:0]       state,
    output logic             fault
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_FAULT  = 3'd5
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_instret;

    if (MEM_TIMEOUT < 1 || MEM_TIMEOUT > 255) begin : g_mem_timeout_range
        $error("multicycle_seq: MEM_TIMEOUT must be within 1..255");
    end

`ifdef SEQ_MEM_TIMEOUT_EN
    localparam logic [7:0] c_timeout_last = 8'(MEM_TIMEOUT - 1);

    logic [7:0] r_wait_cnt;
    logic       r_fault;
    logic       w_timeout_hit;

    // The edge that would push the count to MEM_TIMEOUT is the faulting edge.
    assign w_timeout_hit = (r_wait_cnt == c_timeout_last);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_FETCH;
            r_instret <= '0;
        end else begin
            r_state <= w_next;
            if (retire) begin
                r_instret <= r_instret + CNT_W'(1);
            end
        end
    end

`ifdef SEQ_MEM_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait_cnt <= '0;
            r_fault    <= 1'b0;
        end else begin
            if (w_next != r_state) begin
                r_wait_cnt <= '0;
            end else if ((r_state == S_FETCH || r_state == S_MEM) && !mem_ack) begin
                r_wait_cnt <= r_wait_cnt + 8'd1;
            end
            if (w_next == S_FAULT) begin
                r_fault <= 1'b1;
            end
        end
    end

    assign fault = r_fault;
`else
    assign fault = 1'b0;
`endif

    always_comb begin
        w_next      = r_state;
        mem_req     = 1'b0;
        mem_ifetch  = 1'b0;
        mem_we      = 1'b0;
        ir_we       = 1'b0;
        pc_we       = 1'b0;
        reg_we      = 1'b0;
        reg_we_base = 1'b0;
        flag_we     = 1'b0;
        retire      = 1'b0;

        case (r_state)
            S_FETCH: begin
                mem_req    = 1'b1;
                mem_ifetch = 1'b1;
                if (mem_ack) begin
                    ir_we  = 1'b1;
                    pc_we  = 1'b1;
                    w_next = S_DECODE;
                end
`ifdef SEQ_MEM_TIMEOUT_EN
                else if (w_timeout_hit) begin
                    w_next = S_FAULT;
                end
`endif
            end
            S_DECODE: begin
                w_next = S_EXEC;
            end
            S_EXEC: begin
                // Load/store wins over data-processing on an illegal dual decode.
                if (cond_pass && ldstr) begin
                    w_next = S_MEM;
                end else begin
                    if (cond_pass && datapr) begin
                        reg_we  = regwrite_dec;
                        flag_we = flagupdate_dec;
                    end
                    retire = 1'b1;
                    w_next = S_FETCH;
                end
            end
            S_MEM: begin
                mem_req = 1'b1;
                mem_we  = ~l_bit;
                if (mem_ack) begin
                    if (l_bit) begin
                        w_next = S_WB;
                    end else begin
                        reg_we_base = wb_base;
                        retire      = 1'b1;
                        w_next      = S_FETCH;
                    end
                end
`ifdef SEQ_MEM_TIMEOUT_EN
                else if (w_timeout_hit) begin
                    w_next = S_FAULT;
                end
`endif
            end
            S_WB: begin
                reg_we      = 1'b1;
                reg_we_base = wb_base;
                retire      = 1'b1;
                w_next      = S_FETCH;
            end
            S_FAULT: begin
`ifdef SEQ_MEM_TIMEOUT_EN
                w_next = S_FAULT;
`else
                w_next = S_FETCH;
`endif
            end
            default: begin
                w_next = S_FETCH;
            end
        endcase

        // Reset abandons any access in flight and silences every strobe.
        if (rst) begin
            mem_req     = 1'b0;
            mem_ifetch  = 1'b0;
            mem_we      = 1'b0;
            ir_we       = 1'b0;
            pc_we       = 1'b0;
            reg_we      = 1'b0;
            reg_we_base = 1'b0;
            flag_we     = 1'b0;
            retire      = 1'b0;
        end
    end

    assign instret = r_instret;
    assign state   = r_state;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_seq.sv
//------------------------------------------------------------------------------
// Module      : tb_multicycle_seq
// Description : Self-checking bench for multicycle_seq; instruction-level model
//               expanded into per-cycle expectations.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_multicycle_seq;

    localparam int CNT_W = 32;

    // Strobe vector bit order: req, ifetch, we, ir_we, pc_we, reg_we, base, flag, retire
    localparam logic [8:0] c_req    = 9'b1_0000_0000;
    localparam logic [8:0] c_ifetch = 9'b0_1000_0000;
    localparam logic [8:0] c_we     = 9'b0_0100_0000;
    localparam logic [8:0] c_ir     = 9'b0_0010_0000;
    localparam logic [8:0] c_pc     = 9'b0_0001_0000;
    localparam logic [8:0] c_reg    = 9'b0_0000_1000;
    localparam logic [8:0] c_base   = 9'b0_0000_0100;
    localparam logic [8:0] c_flag   = 9'b0_0000_0010;
    localparam logic [8:0] c_ret    = 9'b0_0000_0001;

    localparam logic [2:0] c_fetch  = 3'd0;
    localparam logic [2:0] c_decode = 3'd1;
    localparam logic [2:0] c_exec   = 3'd2;
    localparam logic [2:0] c_mem    = 3'd3;
    localparam logic [2:0] c_wb     = 3'd4;
    localparam logic [2:0] c_fault  = 3'd5;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             mem_ack = 1'b0;
    logic             cond_pass = 1'b0;
    logic             datapr = 1'b0;
    logic             ldstr = 1'b0;
    logic             l_bit = 1'b0;
    logic             regwrite_dec = 1'b0;
    logic             flagupdate_dec = 1'b0;
    logic             wb_base = 1'b0;
    logic             mem_req, mem_ifetch, mem_we, ir_we, pc_we;
    logic             reg_we, reg_we_base, flag_we, retire, fault;
    logic [CNT_W-1:0] instret;
    logic [2:0]       state;

    always #5 clk = ~clk;

    multicycle_seq #(.MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .mem_ack(mem_ack), .cond_pass(cond_pass),
        .datapr(datapr), .ldstr(ldstr), .l_bit(l_bit),
        .regwrite_dec(regwrite_dec), .flagupdate_dec(flagupdate_dec),
        .wb_base(wb_base), .mem_req(mem_req), .mem_ifetch(mem_ifetch),
        .mem_we(mem_we), .ir_we(ir_we), .pc_we(pc_we), .reg_we(reg_we),
        .reg_we_base(reg_we_base), .flag_we(flag_we), .retire(retire),
        .instret(instret), .state(state), .fault(fault)
    );

    typedef struct {
        bit         rst, ack, cp, dp, ls, l, rw, fu, wb;
        logic [2:0] st;
        logic [8:0] strb;
        int         instret;
        bit         fault;
        int         pin;
    } cyc_t;

    cyc_t q[$];
    cyc_t cur;
    bit   cur_valid = 1'b0;
    int   cyc_no = 0;
    int   checks = 0;
    int   errors = 0;

    // Instruction-level model state
    int m_cnt = 0;
    bit m_fault = 1'b0;
    int m_pin = -1;
    bit m_cp, m_dp, m_ls, m_l, m_rw, m_fu, m_wb;

    task automatic push(bit r, bit a, logic [2:0] st, logic [8:0] strb);
        cyc_t c;
        if (!r && st == c_fault) m_fault = 1'b1;
        c.rst = r; c.ack = a;
        c.cp = m_cp; c.dp = m_dp; c.ls = m_ls; c.l = m_l;
        c.rw = m_rw; c.fu = m_fu; c.wb = m_wb;
        c.st = st; c.strb = strb; c.instret = m_cnt; c.fault = m_fault;
        c.pin = m_pin;
        m_pin = -1;
        q.push_back(c);
        if (r) begin
            m_cnt = 0;
            m_fault = 1'b0;
        end else if (strb[0]) begin
            m_cnt = m_cnt + 1;
        end
    endtask

    // One instruction: fw fetch waits, mw memory waits; abort>=0 resets after that many MEM waits.
    task automatic add_instr(bit cp, bit dp, bit ls, bit l, bit rw, bit fu, bit wb,
                             int fw, int mw, int abort);
        m_cp = cp; m_dp = dp; m_ls = ls; m_l = l; m_rw = rw; m_fu = fu; m_wb = wb;
        for (int i = 0; i < fw; i++) push(1'b0, 1'b0, c_fetch, c_req | c_ifetch);
        push(1'b0, 1'b1, c_fetch, c_req | c_ifetch | c_ir | c_pc);
        push(1'b0, 1'b1, c_decode, 9'b0);
        if (!cp) begin
            push(1'b0, 1'b1, c_exec, c_ret);
        end else if (ls) begin
            push(1'b0, 1'b1, c_exec, 9'b0);
            if (abort >= 0) begin
                for (int i = 0; i < abort; i++) push(1'b0, 1'b0, c_mem, c_req | (l ? 9'b0 : c_we));
                push(1'b1, 1'b0, c_mem, 9'b0);
                return;
            end
            for (int i = 0; i < mw; i++) push(1'b0, 1'b0, c_mem, c_req | (l ? 9'b0 : c_we));
            if (l) begin
                push(1'b0, 1'b1, c_mem, c_req);
                push(1'b0, 1'b1, c_wb, c_reg | (wb ? c_base : 9'b0) | c_ret);
            end else begin
                push(1'b0, 1'b1, c_mem, c_req | c_we | (wb ? c_base : 9'b0) | c_ret);
            end
        end else if (dp) begin
            push(1'b0, 1'b1, c_exec, (rw ? c_reg : 9'b0) | (fu ? c_flag : 9'b0) | c_ret);
        end else begin
            push(1'b0, 1'b1, c_exec, c_ret);
        end
    endtask

    task automatic chk_len(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: model length %0d, required %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (cur_valid) begin
            logic [8:0] act, mask;
            act  = {mem_req, mem_ifetch, mem_we, ir_we, pc_we, reg_we, reg_we_base, flag_we, retire};
            mask = cur.strb[8] ? 9'h1FF : 9'h03F | c_req;
            checks++;
            if ((act & mask) != (cur.strb & mask)) begin
                errors++;
                $display("FAIL strobes cyc=%0d actual=%b required=%b", cyc_no, act & mask, cur.strb & mask);
            end
            if (!cur.rst) begin
                checks++;
                if (state != cur.st) begin
                    errors++;
                    $display("FAIL state cyc=%0d actual=%0d required=%0d", cyc_no, state, cur.st);
                end
                checks++;
                if (instret != CNT_W'(cur.instret)) begin
                    errors++;
                    $display("FAIL instret cyc=%0d actual=%0d required=%0d", cyc_no, instret, cur.instret);
                end
                checks++;
                if (fault != cur.fault) begin
                    errors++;
                    $display("FAIL fault cyc=%0d actual=%0b required=%0b", cyc_no, fault, cur.fault);
                end
            end
            if (cur.pin >= 0) begin
                checks++;
                if (instret != CNT_W'(cur.pin)) begin
                    errors++;
                    $display("FAIL instret_pin cyc=%0d actual=%0d required=%0d", cyc_no, instret, cur.pin);
                end
            end
        end
    end

    initial begin
        int n0;
        {m_cp, m_dp, m_ls, m_l, m_rw, m_fu, m_wb} = '0;
        push(1'b1, 1'b0, c_fetch, 9'b0);
        push(1'b1, 1'b1, c_fetch, 9'b0);
        m_pin = 0;
        // ADD, ack held high
        n0 = q.size(); add_instr(1, 1, 0, 0, 1, 1, 0, 0, 0, -1); chk_len("add_len", q.size() - n0, 3);
        m_pin = 1;
        // LDR with base writeback, ack delayed two MEM cycles
        n0 = q.size(); add_instr(1, 0, 1, 1, 0, 0, 1, 0, 2, -1); chk_len("ldr_len", q.size() - n0, 7);
        m_pin = 2;
        // STR without writeback
        n0 = q.size(); add_instr(1, 0, 1, 0, 0, 0, 0, 0, 0, -1); chk_len("str_len", q.size() - n0, 4);
        m_pin = 3;
        // Squashed data-processing
        n0 = q.size(); add_instr(0, 1, 0, 0, 1, 1, 0, 0, 0, -1); chk_len("squash_len", q.size() - n0, 3);
        m_pin = 4;
        add_instr(1, 1, 0, 0, 0, 1, 0, 2, 0, -1);   // flags only, fetch waits
        add_instr(1, 0, 0, 0, 1, 1, 1, 0, 0, -1);   // NOP class
        add_instr(1, 1, 1, 0, 1, 1, 1, 0, 1, -1);   // illegal dual decode -> store
        add_instr(1, 0, 1, 1, 1, 1, 0, 1, 0, -1);   // LDR no writeback
        add_instr(0, 0, 1, 1, 0, 0, 1, 0, 0, -1);   // squashed load
        m_pin = 9;
        // Reset during a MEM wait
        add_instr(1, 0, 1, 1, 0, 0, 1, 0, 0, 2);
        m_pin = 0;
        add_instr(1, 1, 0, 0, 1, 0, 0, 0, 0, -1);
        m_pin = 1;
`ifdef SEQ_MEM_TIMEOUT_EN
        for (int i = 0; i < 4; i++) push(1'b0, 1'b0, c_fetch, c_req | c_ifetch);
        for (int i = 0; i < 3; i++) push(1'b0, 1'b1, c_fault, 9'b0);
        push(1'b1, 1'b0, c_fault, 9'b0);
        m_pin = 0;
        add_instr(1, 1, 0, 0, 1, 1, 0, 3, 0, -1);   // ack on the last legal wait cycle
        add_instr(1, 0, 1, 0, 0, 0, 1, 0, 3, -1);   // store ack on the last legal wait cycle
        m_pin = 2;
`endif
        push(1'b0, 1'b0, c_fetch, c_req | c_ifetch);

        @(posedge clk);
        #1;
        for (int i = 0; i < q.size(); i++) begin
            cur = q[i];
            rst = cur.rst; mem_ack = cur.ack; cond_pass = cur.cp; datapr = cur.dp;
            ldstr = cur.ls; l_bit = cur.l; regwrite_dec = cur.rw;
            flagupdate_dec = cur.fu; wb_base = cur.wb;
            cyc_no = i;
            cur_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        cur_valid = 1'b0;
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
